// File: rtl/display_scan_ctrl_if.sv
// Bundle of the scan controller's data/control inputs and display outputs.
// The controller connects through the slave modport and its driver through the master modport.
interface display_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  mask_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        load_ack;

  modport master (
    output en, load, digits_in, dp_in, mask_in,
    input  seg, dp, an, frame_done, load_ack
  );

  modport slave (
    input  en, load, digits_in, dp_in, mask_in,
    output seg, dp, an, frame_done, load_ack
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with guard blanking and
// frame-synchronous double-buffered display data.
module display_scan_ctrl #(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned GUARD = 500
) (
  input logic                clk,
  input logic                rst_n,
  display_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam logic [19:0] DWELL_LAST = 20'(DWELL - 1);
  localparam logic [19:0] GUARD_LAST = (GUARD == 0) ? 20'd0 : 20'(GUARD - 1);
  // With no guard time every slot starts straight in DRIVE.
  localparam state_t      SLOT_START = (GUARD == 0) ? DRIVE : BLANK;

  function automatic logic [6:0] decode_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b1110001;
      4'hB:    g = 7'b1001000;
      4'hC:    g = 7'b0011000;
      4'hD:    g = 7'b0110001;
      4'hE:    g = 7'b1111110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  state_t      state_r, state_s;
  logic [1:0]  idx_r, idx_s;
  logic [19:0] cnt_r, cnt_s;
  logic        boundary_s;
  logic        apply_s;

  logic [15:0] act_codes_r, act_codes_s;
  logic [3:0]  act_dp_r, act_dp_s;
  logic [3:0]  act_mask_r, act_mask_s;
  logic [15:0] pend_codes_r;
  logic [3:0]  pend_dp_r;
  logic [3:0]  pend_mask_r;
  logic        pend_valid_r;

  logic [6:0]  seg_r, seg_s;
  logic        dp_r, dp_s;
  logic [3:0]  an_r, an_s;
  logic        frame_done_r, frame_done_s;
  logic        load_ack_r;
  logic        lit_s;
  logic [3:0]  code_s;

  // Next-state sequencing of the scan FSM, digit index and slot counter.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    boundary_s = 1'b0;
    if (!bus.en) begin
      state_s = IDLE;
      idx_s   = 2'd0;
      cnt_s   = 20'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s    = SLOT_START;
          idx_s      = 2'd0;
          cnt_s      = 20'd0;
          boundary_s = 1'b1;
        end
        BLANK: begin
          if (cnt_r == GUARD_LAST) begin
            state_s = DRIVE;
            cnt_s   = 20'd0;
          end else begin
            cnt_s = cnt_r + 20'd1;
          end
        end
        DRIVE: begin
          if (cnt_r == DWELL_LAST) begin
            state_s    = SLOT_START;
            idx_s      = idx_r + 2'd1;
            cnt_s      = 20'd0;
            boundary_s = (idx_r == 2'd3);
          end else begin
            cnt_s = cnt_r + 20'd1;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = 2'd0;
          cnt_s   = 20'd0;
        end
      endcase
    end
  end

  // Active data swaps only at a frame boundary; outputs are decoded from the
  // post-edge state so each registered output matches the state it is in.
  always_comb begin
    apply_s     = boundary_s && pend_valid_r;
    act_codes_s = apply_s ? pend_codes_r : act_codes_r;
    act_dp_s    = apply_s ? pend_dp_r    : act_dp_r;
    act_mask_s  = apply_s ? pend_mask_r  : act_mask_r;
    code_s      = act_codes_s[{idx_s, 2'b00} +: 4];
    lit_s       = (state_s == DRIVE) && act_mask_s[idx_s];
    if (lit_s) begin
      seg_s = decode_glyph(code_s);
      dp_s  = ~act_dp_s[idx_s];
      an_s  = ~(4'b0001 << idx_s);
    end else begin
      seg_s = 7'b1111111;
      dp_s  = 1'b1;
      an_s  = 4'b1111;
    end
    frame_done_s = (state_s == DRIVE) && (idx_s == 2'd3) && (cnt_s == DWELL_LAST);
  end

  // Scan FSM state and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= 2'd0;
      cnt_r        <= 20'd0;
      seg_r        <= 7'b1111111;
      dp_r         <= 1'b1;
      an_r         <= 4'b1111;
      frame_done_r <= 1'b0;
      load_ack_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      seg_r        <= seg_s;
      dp_r         <= dp_s;
      an_r         <= an_s;
      frame_done_r <= frame_done_s;
      load_ack_r   <= apply_s;
    end
  end

  // Active (displayed) data set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_codes_r <= 16'hFFFF;
      act_dp_r    <= 4'h0;
      act_mask_r  <= 4'h0;
    end else begin
      act_codes_r <= act_codes_s;
      act_dp_r    <= act_dp_s;
      act_mask_r  <= act_mask_s;
    end
  end

  // Pending buffer: a load on a boundary edge wins over the clear, so it
  // waits for the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_codes_r <= 16'hFFFF;
      pend_dp_r    <= 4'h0;
      pend_mask_r  <= 4'h0;
      pend_valid_r <= 1'b0;
    end else if (bus.load) begin
      pend_codes_r <= bus.digits_in;
      pend_dp_r    <= bus.dp_in;
      pend_mask_r  <= bus.mask_in;
      pend_valid_r <= 1'b1;
    end else if (apply_s) begin
      pend_valid_r <= 1'b0;
    end else begin
      pend_valid_r <= pend_valid_r;
    end
  end

  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.an         = an_r;
  assign bus.frame_done = frame_done_r;
  assign bus.load_ack   = load_ack_r;

endmodule
